// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types and constants for the UART command responder.
//   state_e     : frame parser / bus master FSM states
//   OP_*        : command opcodes carried in the first frame byte
//   RSP_*       : fixed response bytes returned on the tx stream
//   is_known_op : true for the two opcodes the parser understands
//   csum_step   : one step of the running XOR used by the optional
//                 UART_CMD_CHECKSUM_EN frame checksum
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        BUS  = 3'd4,
        RESP = 3'd5
    } state_e;

    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'

    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_cmd_responder_timer.sv
// -----------------------------------------------------------------------------
// uart_cmd_timer
// Loadable up-counter with clear, enable and a registered expiry flag.
// The counter saturates at LIMIT-1; expired is high exactly while the count
// equals LIMIT-1, so a caller enabling it from zero sees expired on the
// LIMIT-th enabled cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear to zero (priority over load/enable)
//   en         : count up by one
//   load       : load load_val (priority over enable)
//   load_val   : value for load
//   expired    : count == LIMIT-1
// -----------------------------------------------------------------------------
module uart_cmd_timer #(
    parameter int LIMIT = 1024,
    parameter int WIDTH = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_r;
    logic             expired_r;

    // Counter and expiry flag; expiry tracks the value being written to count_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= {WIDTH{1'b0}};
            expired_r <= 1'b0;
        end else if (clr) begin
            count_r   <= {WIDTH{1'b0}};
            expired_r <= 1'b0;
        end else if (load) begin
            count_r   <= load_val;
            expired_r <= (load_val == LAST);
        end else if (en && !expired_r) begin
            count_r   <= count_r + WIDTH'(1);
            expired_r <= ((count_r + WIDTH'(1)) == LAST);
        end else begin
            count_r   <= count_r;
            expired_r <= expired_r;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// uart_cmd_responder
// Parses read/write command frames arriving on the UART rx stream, performs a
// single-beat access on a req/ack bus master port and answers with one byte
// on the tx stream per frame.
//   Frame: OP, ADDR[ADDR_BYTES] (MSB first), DATA (write only)
//   Reply: 'K' after a write, read data after a read, 'E' on bad opcode or
//          bus timeout.
// Build option: define UART_CMD_CHECKSUM_EN to require a trailing XOR byte
// over all preceding frame bytes; a mismatch answers 'E' without bus access.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready     : command byte stream in
//   tx_data/tx_valid/tx_ready     : response byte stream out
//   bus_req/bus_we/bus_addr/
//   bus_wdata                     : bus request, held until bus_ack
//   bus_ack/bus_rdata             : single-cycle completion and read data
// -----------------------------------------------------------------------------
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_BYTES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [8*ADDR_BYTES-1:0] bus_addr,
    output logic [7:0]              bus_wdata,
    input  logic                    bus_ack,
    input  logic [7:0]              bus_rdata
);

    localparam int AW    = 8 * ADDR_BYTES;
    localparam int CNT_W = $clog2(ADDR_BYTES + 1);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_BYTES - 1);

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             op_write_r;
    logic [AW-1:0]    addr_r;
    logic             rx_ready_r;
    logic [7:0]       tx_data_r;
    logic             tx_valid_r;
    logic             bus_req_r;
    logic             bus_we_r;
    logic [AW-1:0]    bus_addr_r;
    logic [7:0]       bus_wdata_r;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       csum_r;
`endif

    logic             rx_fire_s;
    logic             tx_fire_s;
    logic [AW-1:0]    addr_next_s;
    logic             timer_clr_s;
    logic             timer_en_s;
    logic             timer_expired_s;

    assign rx_fire_s   = rx_valid & rx_ready_r;
    assign tx_fire_s   = tx_valid_r & tx_ready;
    // Address register with the incoming byte shifted in at the LSB end.
    assign addr_next_s = AW'({addr_r, rx_data});
    // Timer runs only while a bus request is outstanding and is zero on entry.
    assign timer_clr_s = (state_r != BUS);
    assign timer_en_s  = (state_r == BUS);

    uart_cmd_timer #(
        .LIMIT (TIMEOUT),
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr_s),
        .en       (timer_en_s),
        .load     (1'b0),
        .load_val ({TMR_W{1'b0}}),
        .expired  (timer_expired_s)
    );

    // Frame parser, bus master and response FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            op_write_r  <= 1'b0;
            addr_r      <= {AW{1'b0}};
            rx_ready_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {AW{1'b0}};
            bus_wdata_r <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
            csum_r      <= 8'h00;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (rx_fire_s) begin
                        if (is_known_op(rx_data)) begin
                            op_write_r <= (rx_data == OP_WRITE);
                            cnt_r      <= {CNT_W{1'b0}};
                            rx_ready_r <= 1'b1;
                            state_r    <= ADDR;
`ifdef UART_CMD_CHECKSUM_EN
                            csum_r     <= rx_data;
`endif
                        end else begin
                            // Unknown opcode: answer at once, nothing else of the frame is parsed.
                            rx_ready_r <= 1'b0;
                            tx_data_r  <= RSP_ERR;
                            tx_valid_r <= 1'b1;
                            state_r    <= RESP;
                        end
                    end else begin
                        rx_ready_r <= 1'b1;
                    end
                end

                ADDR: begin
                    if (rx_fire_s) begin
                        addr_r <= addr_next_s;
`ifdef UART_CMD_CHECKSUM_EN
                        csum_r <= csum_step(csum_r, rx_data);
`endif
                        if (cnt_r == CNT_LAST) begin
                            if (op_write_r) begin
                                state_r <= DATA;
                            end else begin
`ifdef UART_CMD_CHECKSUM_EN
                                state_r <= CSUM;
`else
                                rx_ready_r <= 1'b0;
                                bus_req_r  <= 1'b1;
                                bus_we_r   <= 1'b0;
                                bus_addr_r <= addr_next_s;
                                state_r    <= BUS;
`endif
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end

                DATA: begin
                    if (rx_fire_s) begin
                        bus_wdata_r <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                        csum_r      <= csum_step(csum_r, rx_data);
                        state_r     <= CSUM;
`else
                        rx_ready_r  <= 1'b0;
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= 1'b1;
                        bus_addr_r  <= addr_r;
                        state_r     <= BUS;
`endif
                    end else begin
                        bus_wdata_r <= bus_wdata_r;
                    end
                end

`ifdef UART_CMD_CHECKSUM_EN
                CSUM: begin
                    if (rx_fire_s) begin
                        rx_ready_r <= 1'b0;
                        if (rx_data == csum_r) begin
                            bus_req_r  <= 1'b1;
                            bus_we_r   <= op_write_r;
                            bus_addr_r <= addr_r;
                            state_r    <= BUS;
                        end else begin
                            tx_data_r  <= RSP_ERR;
                            tx_valid_r <= 1'b1;
                            state_r    <= RESP;
                        end
                    end else begin
                        csum_r <= csum_r;
                    end
                end
`endif

                BUS: begin
                    // An ack in the timeout cycle is checked first and wins.
                    if (bus_ack) begin
                        bus_req_r  <= 1'b0;
                        tx_data_r  <= op_write_r ? RSP_OK : bus_rdata;
                        tx_valid_r <= 1'b1;
                        state_r    <= RESP;
                    end else if (timer_expired_s) begin
                        bus_req_r  <= 1'b0;
                        tx_data_r  <= RSP_ERR;
                        tx_valid_r <= 1'b1;
                        state_r    <= RESP;
                    end else begin
                        bus_req_r <= 1'b1;
                    end
                end

                RESP: begin
                    if (tx_fire_s) begin
                        tx_valid_r <= 1'b0;
                        rx_ready_r <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        tx_valid_r <= 1'b1;
                    end
                end

                default: begin
                    rx_ready_r <= 1'b0;
                    tx_valid_r <= 1'b0;
                    bus_req_r  <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign rx_ready  = rx_ready_r;
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_responder
// Directed bench for uart_cmd_responder (ADDR_BYTES=2, TIMEOUT=16). Inputs are
// driven 1 time unit after the rising edge and outputs sampled at the same
// point. Frames gain a trailing XOR byte when UART_CMD_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_cmd_responder;
    import uart_cmd_pkg::*;

    localparam int AB = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_cmd_responder #(.ADDR_BYTES(AB), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
        check({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
        check({tag, "_tx_data"},   32'(tx_data),   32'd0);
        check({tag, "_bus_req"},   32'(bus_req),   32'd0);
        check({tag, "_bus_we"},    32'(bus_we),    32'd0);
        check({tag, "_bus_addr"},  32'(bus_addr),  32'd0);
        check({tag, "_bus_wdata"}, 32'(bus_wdata), 32'd0);
    endtask

    // Offer one byte and wait (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            step();
            n++;
        end
        check("rx_ready_wait", 32'(rx_ready), 32'd1);
        if (rx_ready) begin
            step();
        end else begin
            rx_valid = 1'b0;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] data);
        send_byte(op);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        if (op == OP_WRITE) begin
            send_byte(data);
        end else begin
            data = 8'h00;
        end
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(op ^ addr[15:8] ^ addr[7:0] ^ data);
`endif
    endtask

    // Hold ack low for n-1 request cycles, pulse it in the n-th, checking req each cycle.
    task automatic ack_after(input int n, input logic [7:0] rd);
        for (int i = 1; i <= n; i++) begin
            check("req_held", 32'(bus_req), 32'd1);
            if (i == n) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end else begin
                bus_ack   = 1'b0;
            end
            step();
        end
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        check("req_drop_after_ack", 32'(bus_req), 32'd0);
        check("ack_to_tx_valid",    32'(tx_valid), 32'd1);
    endtask

    // Wait (bounded) for a response byte, check it and accept it.
    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (!tx_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check(tag, 32'(tx_data), 32'(exp));
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check({tag, "_done"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;

        // Write 57 12 34 A5, ack in the third request cycle.
        send_frame(OP_WRITE, 16'h1234, 8'hA5);
        check("wr_req",   32'(bus_req),   32'd1);
        check("wr_we",    32'(bus_we),    32'd1);
        check("wr_addr",  32'(bus_addr),  32'h1234);
        check("wr_wdata", 32'(bus_wdata), 32'hA5);
        check("wr_rx_ready_low", 32'(rx_ready), 32'd0);
        ack_after(3, 8'hEE);
        recv_byte("wr_resp", RSP_OK);

        // Read 52 00 10, immediate ack with 5C.
        send_frame(OP_READ, 16'h0010, 8'h00);
        check("rd_we",   32'(bus_we),   32'd0);
        check("rd_addr", 32'(bus_addr), 32'h0010);
        ack_after(1, 8'h5C);
        recv_byte("rd_resp", 8'h5C);

        // Bad opcode answers 'E' without touching the bus.
        send_byte(8'h33);
        check("bad_tx_valid", 32'(tx_valid), 32'd1);
        check("bad_tx_data",  32'(tx_data),  32'(RSP_ERR));
        check("bad_no_req",   32'(bus_req),  32'd0);
        recv_byte("bad_resp", RSP_ERR);
        check("bad_no_req_after", 32'(bus_req), 32'd0);
        send_frame(OP_READ, 16'h0001, 8'h00);
        check("after_bad_addr", 32'(bus_addr), 32'h0001);
        ack_after(2, 8'h77);
        recv_byte("after_bad_resp", 8'h77);

        // Timeout: request stays up exactly TIMEOUT cycles, then 'E'.
        send_frame(OP_WRITE, 16'h0020, 8'h11);
        n = 0;
        while (bus_req && n < 40) begin
            n++;
            step();
        end
        check("to_req_cycles", 32'(n), 32'(TO));
        check("to_tx_valid",   32'(tx_valid), 32'd1);
        check("to_tx_data",    32'(tx_data),  32'(RSP_ERR));
        bus_ack   = 1'b1;
        bus_rdata = 8'hAA;
        step();
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        check("late_ack_data", 32'(tx_data), 32'(RSP_ERR));
        check("late_ack_req",  32'(bus_req), 32'd0);
        recv_byte("to_resp", RSP_ERR);

        // tx stall with a queued rx byte.
        send_frame(OP_READ, 16'h0042, 8'h00);
        ack_after(1, 8'hC3);
        rx_data  = OP_READ;
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_tx_valid", 32'(tx_valid), 32'd1);
            check("stall_tx_data",  32'(tx_data),  32'hC3);
            check("stall_rx_ready", 32'(rx_ready), 32'd0);
            step();
        end
        rx_valid = 1'b0;
        recv_byte("stall_resp", 8'hC3);

        // Reset in the middle of a frame, then a fresh read.
        send_byte(OP_WRITE);
        send_byte(8'h12);
        rst = 1'b1;
        step();
        check_zero("midrst");
        rst = 1'b0;
        send_frame(OP_READ, 16'hABCD, 8'h00);
        check("post_rst_we",   32'(bus_we),   32'd0);
        check("post_rst_addr", 32'(bus_addr), 32'hABCD);
        ack_after(1, 8'h3C);
        recv_byte("post_rst_resp", 8'h3C);

`ifdef UART_CMD_CHECKSUM_EN
        // Good checksum reaches the bus; a bad one answers 'E'.
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h42);
        check("cs_ok_req",  32'(bus_req),  32'd1);
        check("cs_ok_addr", 32'(bus_addr), 32'h0010);
        ack_after(1, 8'h99);
        recv_byte("cs_ok_resp", 8'h99);
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        check("cs_bad_tx_valid", 32'(tx_valid), 32'd1);
        check("cs_bad_no_req",   32'(bus_req),  32'd0);
        recv_byte("cs_bad_resp", RSP_ERR);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
Byte-stream command responder on the client side of the UART block's valid/ready streams. Consumes rx bytes, parses fixed-format read/write command frames, and issues a single-beat request on a simple req/ack system-bus master port. Returns one response byte per frame on the tx stream. Gives a host PC register-level access to the system bus over the serial link.

Parameters:
ADDR_BYTES, 2, number of address bytes per frame, MSB first; bus_addr width = 8*ADDR_BYTES.
TIMEOUT, 1024, maximum cycles to wait for bus_ack before aborting; must be >= 2.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
rx_data  input  8  received byte; connects to UART data_rx.
rx_valid  input  1  rx byte valid.
rx_ready  output  1  responder accepts the rx byte.
tx_data  output  8  response byte; connects to UART data_tx.
tx_valid  output  1  response byte valid.
tx_ready  input  1  UART tx accepts the byte.
bus_req  output  1  bus request, held until bus_ack.
bus_we  output  1  1 = write, 0 = read.
bus_addr  output  8*ADDR_BYTES  bus address.
bus_wdata  output  8  write data.
bus_ack  input  1  single-cycle completion strobe.
bus_rdata  input  8  read data; valid in the bus_ack cycle.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, byte counter is 0, and the timeout counter is 0. A reset mid-frame or mid-bus-request drops everything immediately. No response byte is sent.
- Frame format: OP, ADDR[ADDR_BYTES], then DATA only if OP=0x57.
  - OP 0x57 'W' = write; OP 0x52 'R' = read.
- Handshakes: rx and tx transfers occur on cycles where valid and ready are both high. tx_valid/tx_data stay stable until tx_ready.
- rx_ready = 1 only in IDLE, ADDR, DATA (and CSUM when enabled). It is 0 in all other states, which backpressures the UART.
- FSM states and transitions:
  - IDLE: accept OP.
    - 'W' or 'R' -> ADDR with cnt=0.
    - Any other byte -> RESP with tx_data=0x45 'E'.
  - ADDR: shift each byte into the addr register (MSB first); cnt++.
    - After the last address byte -> DATA for 'W'; -> BUS for 'R' (-> CSUM when enabled).
  - DATA: latch wdata -> BUS (-> CSUM when enabled).
  - BUS: bus_req=1 with bus_we/addr/wdata stable; timer counts up from 0.
    - bus_ack -> RESP. tx_data = 0x4B 'K' for a write, bus_rdata for a read. bus_req drops in the following cycle.
    - bus_ack is ignored outside BUS.
    - Timer reaches TIMEOUT-1 without ack -> drop bus_req, go to RESP with 0x45.
    - An ack arriving in the same cycle as the timeout wins, giving a normal response.
  - RESP: tx_valid=1. On tx_ready -> IDLE.
- Latency:
  - Last frame byte accepted -> bus_req is high the next cycle.
  - bus_ack -> tx_valid is high the next cycle.
  - Read data is captured in the ack cycle.
- Only one frame is in flight at a time; bytes are not buffered while in BUS or RESP.

Optional Feature:
UART_CMD_CHECKSUM_EN:
- Defined: every frame carries a trailing XOR byte over all preceding frame bytes, accepted in state CSUM.
  - Mismatch -> RESP 0x45 with no bus access.
  - Match -> BUS.
  - Bad-opcode frames still respond 'E' immediately without waiting for a checksum.
- Undefined: there is no CSUM state and the frame format is as listed above.

Decomposition:
- Package uart_cmd_pkg holds:
  - state enum (IDLE, ADDR, DATA, CSUM, BUS, RESP);
  - constants OP_WRITE=8'h57, OP_READ=8'h52, RSP_OK=8'h4B, RSP_ERR=8'h45.
- One sub-module, uart_cmd_timer: loadable up-counter with clear, enable and expiry flag, used for the bus timeout.
- The frame parser stays flat in the top module.

Test Plan:
- Write 57 12 34 A5, bus acks after 3 cycles -> bus_addr=16'h1234, bus_we=1, bus_wdata=A5, req held 3 cycles, then tx 4B.
- Read 52 00 10, bus_rdata=5C with ack -> bus_we=0, bus_addr=16'h0010, tx 5C.
- Bad opcode 33 -> tx 45, no bus_req. Next frame 52 00 01 is then processed normally.
- No bus_ack, TIMEOUT=16 -> bus_req high exactly 16 cycles, then tx 45. A late ack afterward is ignored.
- tx_ready held low 10 cycles in RESP -> tx_data stable, rx_ready=0 throughout, with rx_valid asserted on a queued byte.
- rst asserted after 57 12 -> outputs zero the next cycle. Then 52 AB CD is decoded as a fresh read of 16'hABCD.
- (UART_CMD_CHECKSUM_EN) 52 00 10 42 -> bus read. 52 00 10 00 -> tx 45, no bus_req.
